// File: rtl/ifu.sv
// Instruction fetch unit: one-outstanding-request fetch engine with a one-entry
// stall buffer, redirect/flush handling and a registered decode-stage output.
module ifu #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_F,
    input  logic        flush_F,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    state_t      state_q, state_d;
    logic        active_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        vld_p1, vld_p1_d;
    logic [31:0] instr_p1, instr_p1_d;
    logic [31:0] pc_p1, pc_p1_d;
    logic [31:0] pc4_p1, pc4_p1_d;
    logic        ack_eff;
    logic [31:0] pc_inc;

    // active_q keeps imem_req low until the first edge after reset release,
    // so an ack seen before that edge can never be mistaken for a response.
    assign imem_req   = active_q && (state_q != S_HOLD);
    assign imem_addr  = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    assign fetch_busy = imem_req && !imem_ack;
    assign ack_eff    = imem_req && imem_ack;
    assign pc_inc     = pc_q + 32'd4;

    assign valid_D    = vld_p1;
    assign instr_D    = instr_p1;
    assign pc_D       = pc_p1;
    assign pc_plus4_D = pc4_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_REQ;
            active_q    <= 1'b0;
            pc_q        <= RESET_VECTOR;
            disc_addr_q <= 32'd0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            vld_p1      <= 1'b0;
            instr_p1    <= NOP_INSTR;
            pc_p1       <= 32'd0;
            pc4_p1      <= 32'd0;
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            vld_p1      <= vld_p1_d;
            instr_p1    <= instr_p1_d;
            pc_p1       <= pc_p1_d;
            pc4_p1      <= pc4_p1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        vld_p1_d    = vld_p1;
        instr_p1_d  = instr_p1;
        pc_p1_d     = pc_p1;
        pc4_p1_d    = pc4_p1;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d       = word_align(redirect_addr);
                    vld_p1_d   = 1'b0;
                    instr_p1_d = NOP_INSTR;
                    if (active_q && !imem_ack) begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (flush_F) begin
                    // A word returned alongside a flush is dropped and refetched.
                    vld_p1_d   = 1'b0;
                    instr_p1_d = NOP_INSTR;
                end else if (ack_eff) begin
                    pc_d = pc_inc;
                    if (stall_F) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        state_d     = S_HOLD;
                    end else begin
                        vld_p1_d   = 1'b1;
                        instr_p1_d = imem_rdata;
                        pc_p1_d    = pc_q;
                        pc4_p1_d   = pc_inc;
                    end
                end else if (!stall_F) begin
                    vld_p1_d   = 1'b0;
                    instr_p1_d = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = word_align(redirect_addr);
                    vld_p1_d   = 1'b0;
                    instr_p1_d = NOP_INSTR;
                    state_d    = S_REQ;
                end else if (flush_F) begin
                    vld_p1_d   = 1'b0;
                    instr_p1_d = NOP_INSTR;
                    state_d    = S_REQ;
                end else if (!stall_F) begin
                    vld_p1_d   = 1'b1;
                    instr_p1_d = buf_instr_q;
                    pc_p1_d    = buf_pc_q;
                    pc4_p1_d   = buf_pc_q + 32'd4;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                vld_p1_d   = 1'b0;
                instr_p1_d = NOP_INSTR;
                if (redirect_valid) begin
                    pc_d = word_align(redirect_addr);
                end
                if (ack_eff) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the fetch rules.
module tb_ifu;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_F, flush_F, redirect_valid, imem_ack;
    logic [31:0] redirect_addr, imem_rdata;
    logic        imem_req, valid_D, fetch_busy;
    logic [31:0] imem_addr, instr_D, pc_D, pc_plus4_D;

    int errors = 0;
    int checks = 0;

    // Model state
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_drop;
    logic [31:0] m_drop_addr;
    logic [31:0] m_buf_i[$];
    logic [31:0] m_buf_pc[$];
    bit          m_vld;
    logic [31:0] m_instr, m_pcd, m_pc4;

    ifu #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset_n(reset_n),
        .stall_F(stall_F), .flush_F(flush_F),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
        .pc_plus4_D(pc_plus4_D), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_pc      = RV;
        m_drop    = 0;
        m_buf_i.delete();
        m_buf_pc.delete();
        m_vld     = 0;
        m_instr   = NOP;
        m_pcd     = 0;
        m_pc4     = 0;
    endtask

    task automatic bubble();
        m_vld   = 0;
        m_instr = NOP;
    endtask

    task automatic model_update(input bit st, input bit fl, input bit rd,
                                input logic [31:0] ra, input bit ak);
        bit req, got;
        req = m_started && (m_buf_i.size() == 0);
        got = req && ak;
        if (rd) begin
            if (req && !ak && !m_drop) begin
                m_drop      = 1;
                m_drop_addr = m_pc;
            end
            if (got) m_drop = 0;
            m_pc = {ra[31:2], 2'b00};
            m_buf_i.delete();
            m_buf_pc.delete();
            bubble();
        end else if (m_drop) begin
            if (got) m_drop = 0;
            bubble();
        end else if (fl) begin
            m_buf_i.delete();
            m_buf_pc.delete();
            bubble();
        end else if (m_buf_i.size() != 0) begin
            if (!st) begin
                m_vld   = 1;
                m_instr = m_buf_i.pop_front();
                m_pcd   = m_buf_pc.pop_front();
                m_pc4   = m_pcd + 32'd4;
            end
        end else if (got) begin
            if (st) begin
                m_buf_i.push_back(mem_word(m_pc));
                m_buf_pc.push_back(m_pc);
            end else begin
                m_vld   = 1;
                m_instr = mem_word(m_pc);
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            bubble();
        end
        m_started = 1;
    endtask

    // Called at a falling edge: drive inputs, compare, clock, advance the model.
    task automatic step(input bit st, input bit fl, input bit rd,
                        input logic [31:0] ra, input bit ak);
        bit exp_req;
        stall_F        = st;
        flush_F        = fl;
        redirect_valid = rd;
        redirect_addr  = ra;
        imem_ack       = ak;
        imem_rdata     = mem_word(imem_addr);
        #1;
        exp_req = m_started && (m_buf_i.size() == 0);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
        chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, exp_req && !ak});
        chk("valid_D", {31'd0, valid_D}, {31'd0, m_vld});
        chk("instr_D", instr_D, m_instr);
        chk("pc_D", pc_D, m_pcd);
        chk("pc_plus4_D", pc_plus4_D, m_pc4);
        @(posedge clk);
        model_update(st, fl, rd, ra, ak);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 0; stall_F = 0; flush_F = 0; redirect_valid = 0;
        redirect_addr = 0; imem_ack = 1; imem_rdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid_D", {31'd0, valid_D}, 32'd0);
        chk("rst_instr_D", instr_D, NOP);
        chk("rst_pc_D", pc_D, 32'd0);
        chk("rst_pc_plus4_D", pc_plus4_D, 32'd0);
        chk("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
        @(negedge clk);
        reset_n = 1;

        // Reset release with ack tied high
        step(0, 0, 0, 0, 1);
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, RV);
        step(0, 0, 0, 0, 1);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_valid", {31'd0, valid_D}, 32'd1);
        chk("seq_pcD0", pc_D, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_pcD4", pc_D, 32'h4);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Stall for three cycles while 0x10 returns
        chk("stall_pre_addr", imem_addr, 32'h10);
        step(1, 0, 0, 0, 1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pcD", pc_D, 32'hC);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("hold_pcD_frozen", pc_D, 32'hC);
        step(0, 0, 0, 0, 1);
        chk("release_pcD", pc_D, 32'h10);
        chk("release_addr", imem_addr, 32'h14);

        // Delayed ack at 0x20 with redirect in the first wait cycle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("wait_addr", imem_addr, 32'h20);
        step(0, 0, 1, 32'h103, 0);
        chk("disc_addr1", imem_addr, 32'h20);
        chk("disc_valid", {31'd0, valid_D}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("disc_addr3", imem_addr, 32'h20);
        step(0, 0, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_novalid", {31'd0, valid_D}, 32'd0);
        step(0, 0, 0, 0, 1);
        chk("redir_pcD", pc_D, 32'h100);

        // Flush together with stall
        step(1, 1, 0, 0, 0);
        chk("flush_valid", {31'd0, valid_D}, 32'd0);
        chk("flush_instr", instr_D, 32'h0000_0013);
        chk("flush_pc", imem_addr, 32'h104);

        // PC wrap at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 0, 0, 1);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1);
        chk("wrap_pcD", pc_D, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_D, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);

        // Reset during an outstanding request at 0x40
        step(0, 0, 1, 32'h40, 1);
        step(0, 0, 0, 0, 0);
        chk("mid_addr", imem_addr, 32'h40);
        reset_n  = 0;
        imem_ack = 1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid_D}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        step(0, 0, 0, 0, 1);
        chk("mid_boot_req", {31'd0, imem_req}, 32'd1);
        chk("mid_boot_addr", imem_addr, RV);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit st, fl, rd, ak;
            logic [31:0] ra;
            st = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 8);
            rd = ($urandom_range(0, 99) < 8);
            ak = ($urandom_range(0, 99) < 60);
            ra = $urandom();
            if (ra[4]) ra = 32'hFFFF_FFF0 | ra[3:0];
            step(st, fl, rd, ra, ak);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
